// File: rtl/loader_sequencer.sv
// Loader sequencer: parses {element, start address, count} packets from a byte stream
// and issues one SELECT strobe per payload word. Optional trailer check: LOADER_SEQUENCER_CHECKSUM_EN.
module loader_sequencer #(
    parameter int ADDRESS_SIZE = 9,
    parameter int DATA_SIZE    = 8,
    parameter int NB_ELEMENTS  = 3,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [7:0]              IN_DATA,
    output logic                    SELECT,
    output logic [ADDRESS_SIZE-1:0] ADDRESS,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERR
);
    localparam int ELEM_W  = $clog2(NB_ELEMENTS);
    localparam int LOCAL_W = ADDRESS_SIZE - ELEM_W;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_ADDR, S_HDR_CNT, S_WAIT_DATA, S_STROBE, S_GAP, S_DRAIN, S_CHECK
    } state_t;

    state_t                  state_q, state_d;
    logic [ELEM_W-1:0]       elem_q, elem_d;
    logic                    bad_q, bad_d;
    logic [LOCAL_W-1:0]      loc_q, loc_d;
    logic [8:0]              cnt_q, cnt_d;
    logic [3:0]              gap_q, gap_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0]    data_q, data_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    ready_s;
    logic                    accept;
    state_t                  end_state;
    logic                    end_done;
`ifdef LOADER_SEQUENCER_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    assign accept = IN_VALID && IN_READY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            bad_q   <= 1'b0;
            loc_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_SEQUENCER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            bad_q   <= bad_d;
            loc_q   <= loc_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef LOADER_SEQUENCER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Where the FSM goes once the final payload word has been strobed.
    always_comb begin
`ifdef LOADER_SEQUENCER_CHECKSUM_EN
        end_state = S_CHECK;
        end_done  = 1'b0;
`else
        end_state = S_IDLE;
        end_done  = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        bad_d   = bad_q;
        loc_d   = loc_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef LOADER_SEQUENCER_CHECKSUM_EN
        csum_d  = csum_q;
        if (accept) csum_d = (state_q == S_IDLE) ? IN_DATA : (csum_q ^ IN_DATA);
`endif
        case (state_q)
            S_IDLE: if (accept) begin
                elem_d  = IN_DATA[ELEM_W-1:0];
                bad_d   = (IN_DATA >= 8'(NB_ELEMENTS));
                state_d = S_HDR_ADDR;
            end
            S_HDR_ADDR: if (accept) begin
                loc_d   = IN_DATA[LOCAL_W-1:0];
                state_d = S_HDR_CNT;
            end
            S_HDR_CNT: if (accept) begin
                // A zero count encodes 256 words.
                cnt_d   = {(IN_DATA == 8'd0), IN_DATA};
                state_d = bad_q ? S_DRAIN : S_WAIT_DATA;
`ifdef LOADER_SEQUENCER_CHECKSUM_EN
                if (bad_q) cnt_d = {(IN_DATA == 8'd0), IN_DATA} + 9'd1;
`endif
            end
            S_WAIT_DATA: if (accept) begin
                data_d  = IN_DATA;
                addr_d  = {elem_q, loc_q};
                loc_d   = loc_q + LOCAL_W'(1);
                cnt_d   = cnt_q - 9'd1;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (GAP_CYCLES > 0) begin
                    gap_d   = 4'(GAP_CYCLES - 1);
                    state_d = S_GAP;
                end else if (cnt_q == 9'd0) begin
                    state_d = end_state;
                    done_d  = end_done;
                end else begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_GAP: begin
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (cnt_q == 9'd0) begin
                    state_d = end_state;
                    done_d  = end_done;
                end else begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_DRAIN: if (accept) begin
                cnt_d = cnt_q - 9'd1;
                if (cnt_q == 9'd1) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_CHECK: begin
`ifdef LOADER_SEQUENCER_CHECKSUM_EN
                if (accept) begin
                    state_d = S_IDLE;
                    done_d  = (IN_DATA == csum_q);
                    err_d   = (IN_DATA != csum_q);
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_s = 1'b0;
        case (state_q)
            S_IDLE, S_HDR_ADDR, S_HDR_CNT, S_WAIT_DATA, S_DRAIN: ready_s = 1'b1;
`ifdef LOADER_SEQUENCER_CHECKSUM_EN
            S_CHECK: ready_s = 1'b1;
`endif
            default: ready_s = 1'b0;
        endcase
        IN_READY = ready_s && !RESET;
        SELECT   = (state_q == S_STROBE);
        BUSY     = (state_q != S_IDLE);
        ADDRESS  = addr_q;
        DATA_OUT = data_q;
        DONE     = done_q;
        ERR      = err_q;
    end
endmodule

// File: tb/tb_loader_sequencer.sv
// Directed bench for loader_sequencer; also exercises the checksum trailer when
// LOADER_SEQUENCER_CHECKSUM_EN is defined.
module tb_loader_sequencer;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] IN_DATA;
    logic       SELECT;
    logic [8:0] ADDRESS;
    logic [7:0] DATA_OUT;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    int checks = 0;
    int errors = 0;

    int         sel_cnt = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         dbl_sel = 0;
    logic       prev_sel = 1'b0;
    logic [8:0] sel_addr [0:1023];
    logic [7:0] sel_data [0:1023];
    logic [7:0] cs;

    int base_sel, base_done, base_err;

    loader_sequencer dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_DATA(IN_DATA), .SELECT(SELECT), .ADDRESS(ADDRESS), .DATA_OUT(DATA_OUT),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (SELECT) begin
            sel_addr[sel_cnt] <= ADDRESS;
            sel_data[sel_cnt] <= DATA_OUT;
            sel_cnt <= sel_cnt + 1;
        end
        if (DONE) done_cnt <= done_cnt + 1;
        if (ERR) err_cnt <= err_cnt + 1;
        if (SELECT && prev_sel) dbl_sel <= dbl_sel + 1;
        prev_sel <= SELECT;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int k;
        k = 0;
        IN_VALID = 1'b1;
        IN_DATA  = b;
        while (!IN_READY && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 200) chk("ready_timeout", 32'(k), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        cs = cs ^ b;
    endtask

    task automatic finish_pkt();
`ifdef LOADER_SEQUENCER_CHECKSUM_EN
        logic [7:0] c;
        c = cs;
        send(c);
`endif
    endtask

    task automatic snap();
        base_sel  = sel_cnt;
        base_done = done_cnt;
        base_err  = err_cnt;
        cs        = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        RESET    = 1'b1;
        IN_VALID = 1'b0;
        IN_DATA  = 8'h00;
        cs       = 8'h00;
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(IN_READY), 32'd0);
        chk("rst_select", 32'(SELECT), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_addr", 32'(ADDRESS), 32'd0);
        chk("rst_done_err", 32'({DONE, ERR}), 32'd0);
        RESET = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("post_rst_ready", 32'(IN_READY), 32'd1);

        // Basic three-word packet to element 1, local 0x10.
        snap();
        send(8'h01); send(8'h10); send(8'h03);
        chk("t1_busy", 32'(BUSY), 32'd1);
        send(8'hAA);
        chk("t1_sel_latency", 32'(SELECT), 32'd1);
        chk("t1_addr0_now", 32'(ADDRESS), 32'h090);
        chk("t1_ready_in_strobe", 32'(IN_READY), 32'd0);
        send(8'hBB); send(8'hCC);
        finish_pkt();
        idle(4);
        chk("t1_nsel", 32'(sel_cnt - base_sel), 32'd3);
        chk("t1_addr0", 32'(sel_addr[base_sel]), 32'h090);
        chk("t1_addr1", 32'(sel_addr[base_sel+1]), 32'h091);
        chk("t1_addr2", 32'(sel_addr[base_sel+2]), 32'h092);
        chk("t1_data0", 32'(sel_data[base_sel]), 32'hAA);
        chk("t1_data1", 32'(sel_data[base_sel+1]), 32'hBB);
        chk("t1_data2", 32'(sel_data[base_sel+2]), 32'hCC);
        chk("t1_done", 32'(done_cnt - base_done), 32'd1);
        chk("t1_err", 32'(err_cnt - base_err), 32'd0);
        chk("t1_hold_addr", 32'(ADDRESS), 32'h092);
        chk("t1_idle", 32'(BUSY), 32'd0);

        // Local address wrap, element 2 preserved.
        snap();
        send(8'h02); send(8'h7F); send(8'h02); send(8'h11); send(8'h22);
        finish_pkt();
        idle(4);
        chk("t2_nsel", 32'(sel_cnt - base_sel), 32'd2);
        chk("t2_addr0", 32'(sel_addr[base_sel]), 32'h17F);
        chk("t2_addr1", 32'(sel_addr[base_sel+1]), 32'h100);
        chk("t2_done", 32'(done_cnt - base_done), 32'd1);

        // Invalid element: drained silently, ERR only.
        snap();
        send(8'h03); send(8'h00); send(8'h02); send(8'h55); send(8'h66);
        finish_pkt();
        idle(4);
        chk("t3_nsel", 32'(sel_cnt - base_sel), 32'd0);
        chk("t3_err", 32'(err_cnt - base_err), 32'd1);
        chk("t3_done", 32'(done_cnt - base_done), 32'd0);
        chk("t3_idle", 32'(BUSY), 32'd0);

        // 256-word packet with random valid gaps.
        snap();
        send(8'h00); send(8'h00); send(8'h00);
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            send(8'(i));
        end
        finish_pkt();
        idle(5);
        chk("t4_nsel", 32'(sel_cnt - base_sel), 32'd256);
        for (int i = 0; i < 256; i++) begin
            chk("t4_addr", 32'(sel_addr[base_sel+i]), 32'(i & 32'h7F));
            chk("t4_data", 32'(sel_data[base_sel+i]), 32'(i & 32'hFF));
        end
        chk("t4_done", 32'(done_cnt - base_done), 32'd1);
        chk("t4_err", 32'(err_cnt - base_err), 32'd0);

        // Reset in the middle of a four-word packet.
        snap();
        send(8'h01); send(8'h00); send(8'h04); send(8'h11); send(8'h22);
        RESET = 1'b1;
        @(negedge CLK);
        chk("t5_sel_after_rst", 32'(SELECT), 32'd0);
        chk("t5_busy_after_rst", 32'(BUSY), 32'd0);
        chk("t5_ready_in_rst", 32'(IN_READY), 32'd0);
        RESET = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("t5_ready_after_rst", 32'(IN_READY), 32'd1);
        idle(3);
        chk("t5_nsel", 32'(sel_cnt - base_sel), 32'd2);
        chk("t5_no_done_err", 32'((done_cnt - base_done) + (err_cnt - base_err)), 32'd0);
        snap();
        send(8'h01); send(8'h20); send(8'h01); send(8'h77);
        finish_pkt();
        idle(4);
        chk("t5_fresh_nsel", 32'(sel_cnt - base_sel), 32'd1);
        chk("t5_fresh_addr", 32'(sel_addr[base_sel]), 32'h0A0);
        chk("t5_fresh_data", 32'(sel_data[base_sel]), 32'h77);
        chk("t5_fresh_done", 32'(done_cnt - base_done), 32'd1);

`ifdef LOADER_SEQUENCER_CHECKSUM_EN
        snap();
        send(8'h01); send(8'h10); send(8'h01); send(8'hAA); send(8'hBA);
        idle(3);
        chk("cs_good_done", 32'(done_cnt - base_done), 32'd1);
        chk("cs_good_err", 32'(err_cnt - base_err), 32'd0);
        snap();
        send(8'h01); send(8'h10); send(8'h01); send(8'hAA); send(8'h00);
        idle(3);
        chk("cs_bad_err", 32'(err_cnt - base_err), 32'd1);
        chk("cs_bad_done", 32'(done_cnt - base_done), 32'd0);
        chk("cs_bad_nsel", 32'(sel_cnt - base_sel), 32'd1);
        chk("cs_bad_addr", 32'(sel_addr[base_sel]), 32'h090);
`endif

        chk("never_double_select", 32'(dbl_sel), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end
endmodule
